frame_transfer_receiver: RTL and testbench

//  Destination end of the frame transfer interface (tIFrameTransfer dest modport signals, as discrete ports).

---
 rtl/frame_transfer_receiver.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_frame_transfer_receiver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_transfer_receiver.sv
// ---------------------------------------------------------------------------
// frame_transfer_receiver
//
// Destination end of the frame transfer interface. RGB24 macroblock beats are
// accepted under ul1Ready flow control and buffered in a FIFO. Macroblock
// length, type consistency and frame framing are checked on the way in. The
// FIFO head is presented to downstream logic as a valid/ready stream.
//
// Ports
//   ul1Clock          in   single clock for all logic
//   ul1Reset_n        in   asynchronous active-low reset
//   ul1SrcReset_n     in   synchronous active-low flush from the source
//   ul1Active         in   source is transferring; beat valid qualifier
//   eMacroBlockType   in   type of the current macroblock
//   ul24Rgb24Data     in   pixel data
//   ul1MacroBlockEnd  in   last pixel of the macroblock
//   ul1Ready          out  receiver can accept a beat this cycle (registered)
//   ul1OutValid       out  FIFO head valid
//   ul24OutData       out  FIFO head pixel
//   eOutType          out  FIFO head macroblock type
//   ul1OutMbEnd       out  FIFO head is last pixel of its macroblock
//   ul1OutFrameStart  out  FIFO head is first pixel of a frame
//   ul1OutReady       in   downstream accepts the head
//   ul1FrameDone      out  one-cycle pulse at a clean frame end
//   ul16MbCount       out  macroblocks completed in current/last frame (saturating)
//   ul1LengthError    out  sticky: macroblock length mismatch
//   ul1TypeError      out  sticky: type changed inside a macroblock
//   ul1TruncError     out  sticky: ul1Active dropped mid-macroblock
//   ul1ErrClear       in   clears all sticky errors
// ---------------------------------------------------------------------------
package frame_transfer_pkg;
    typedef enum logic [1:0] {
        MB_TYPE_I    = 2'd0,
        MB_TYPE_P    = 2'd1,
        MB_TYPE_B    = 2'd2,
        MB_TYPE_SKIP = 2'd3
    } teMacroBlockType;
endpackage

module frame_transfer_receiver
    import frame_transfer_pkg::*;
#(
    parameter int MB_PIXELS  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            ul1Clock,
    input  logic            ul1Reset_n,
    input  logic            ul1SrcReset_n,
    input  logic            ul1Active,
    input  teMacroBlockType eMacroBlockType,
    input  logic [23:0]     ul24Rgb24Data,
    input  logic            ul1MacroBlockEnd,
    output logic            ul1Ready,
    output logic            ul1OutValid,
    output logic [23:0]     ul24OutData,
    output teMacroBlockType eOutType,
    output logic            ul1OutMbEnd,
    output logic            ul1OutFrameStart,
    input  logic            ul1OutReady,
    output logic            ul1FrameDone,
    output logic [15:0]     ul16MbCount,
    output logic            ul1LengthError,
    output logic            ul1TypeError,
    output logic            ul1TruncError,
    input  logic            ul1ErrClear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PC_W  = $clog2(MB_PIXELS);
    localparam int ENT_W = 28;

    localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(MB_PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RECEIVE = 1'b1;

    // FIFO entry layout: {FrameStart[27], Type[26:25], MbEnd[24], Data[23:0]}
    function automatic logic [ENT_W-1:0] pack_entry(
        input logic            fs,
        input teMacroBlockType typ,
        input logic            mb_end,
        input logic [23:0]     pix
    );
        pack_entry = {fs, typ, mb_end, pix};
    endfunction

    logic [ENT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             valid_r;
    logic             ready_r;
    logic [0:0]       state_r;
    logic [PC_W-1:0]  pc_r;
    teMacroBlockType  type_r;
    logic [15:0]      mb_count_r;
    logic             frame_done_r;
    logic             len_err_r;
    logic             type_err_r;
    logic             trunc_err_r;

    logic             accept_s;
    logic             read_s;
    logic [CNT_W-1:0] count_next_s;
    logic [ENT_W-1:0] entry_s;
    logic [ENT_W-1:0] head_s;
    logic [0:0]       state_next_s;
    logic [PC_W-1:0]  pc_next_s;
    teMacroBlockType  type_next_s;
    logic [15:0]      mb_base_s;
    logic [15:0]      mb_count_next_s;
    logic             frame_start_s;
    logic             done_s;
    logic             len_set_s;
    logic             type_set_s;
    logic             trunc_set_s;

    assign accept_s     = ul1Active & ready_r;
    assign read_s       = valid_r & ul1OutReady;
    assign count_next_s = count_r + CNT_W'(accept_s) - CNT_W'(read_s);
    assign entry_s      = pack_entry(frame_start_s, eMacroBlockType, ul1MacroBlockEnd, ul24Rgb24Data);
    assign head_s       = mem_r[rd_ptr_r];

    // Frame/macroblock tracking: next state, pixel counter, MB count and error events
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        type_next_s     = type_r;
        mb_base_s       = mb_count_r;
        mb_count_next_s = mb_count_r;
        frame_start_s   = 1'b0;
        done_s          = 1'b0;
        len_set_s       = 1'b0;
        type_set_s      = 1'b0;
        trunc_set_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    // First beat of a frame restarts the macroblock count
                    state_next_s    = ST_RECEIVE;
                    frame_start_s   = 1'b1;
                    mb_base_s       = 16'd0;
                    mb_count_next_s = 16'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECEIVE: begin
                if (!ul1Active) begin
                    state_next_s = ST_IDLE;
                    pc_next_s    = PC_ZERO;
                    if (pc_r == PC_ZERO) begin
                        done_s = 1'b1;
                    end else begin
                        trunc_set_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_RECEIVE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                pc_next_s    = PC_ZERO;
            end
        endcase

        if (accept_s) begin
            if (pc_r == PC_ZERO) begin
                type_next_s = eMacroBlockType;
            end else if (eMacroBlockType != type_r) begin
                type_set_s = 1'b1;
            end else begin
                type_set_s = 1'b0;
            end

            // A macroblock closes on MbEnd or on its last pixel slot, whichever comes first
            if (ul1MacroBlockEnd || (pc_r == PC_LAST)) begin
                pc_next_s       = PC_ZERO;
                len_set_s       = ~(ul1MacroBlockEnd & (pc_r == PC_LAST));
                mb_count_next_s = (mb_base_s == 16'hFFFF) ? mb_base_s : (mb_base_s + 16'd1);
            end else begin
                pc_next_s = pc_r + PC_W'(1);
            end
        end else begin
            type_set_s = 1'b0;
        end
    end

    // FIFO storage; contents only matter while counted as occupied
    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
        end else if (ul1SrcReset_n && accept_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy, and the registered valid/ready flags
    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
            ready_r  <= 1'b0;
        end else if (!ul1SrcReset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(accept_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(read_s);
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != {CNT_W{1'b0}});
            ready_r  <= (count_next_s < CNT_FULL);
        end
    end

    // Frame FSM, pixel counter, latched type and macroblock count
    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= PC_ZERO;
            type_r       <= MB_TYPE_I;
            mb_count_r   <= 16'd0;
            frame_done_r <= 1'b0;
        end else if (!ul1SrcReset_n) begin
            // Flush abandons the frame but keeps the count of what was completed
            state_r      <= ST_IDLE;
            pc_r         <= PC_ZERO;
            type_r       <= type_r;
            mb_count_r   <= mb_count_r;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            type_r       <= type_next_s;
            mb_count_r   <= mb_count_next_s;
            frame_done_r <= done_s;
        end
    end

    // Sticky error flags; a new error in the same cycle wins over the clear
    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            len_err_r   <= 1'b0;
            type_err_r  <= 1'b0;
            trunc_err_r <= 1'b0;
        end else if (!ul1SrcReset_n) begin
            len_err_r   <= len_err_r   & ~ul1ErrClear;
            type_err_r  <= type_err_r  & ~ul1ErrClear;
            trunc_err_r <= trunc_err_r & ~ul1ErrClear;
        end else begin
            len_err_r   <= len_set_s   | (len_err_r   & ~ul1ErrClear);
            type_err_r  <= type_set_s  | (type_err_r  & ~ul1ErrClear);
            trunc_err_r <= trunc_set_s | (trunc_err_r & ~ul1ErrClear);
        end
    end

    assign ul1Ready         = ready_r;
    assign ul1OutValid      = valid_r;
    assign ul1OutFrameStart = head_s[27];
    assign eOutType         = teMacroBlockType'(head_s[26:25]);
    assign ul1OutMbEnd      = head_s[24];
    assign ul24OutData      = head_s[23:0];
    assign ul1FrameDone     = frame_done_r;
    assign ul16MbCount      = mb_count_r;
    assign ul1LengthError   = len_err_r;
    assign ul1TypeError     = type_err_r;
    assign ul1TruncError    = trunc_err_r;

endmodule

// File: tb/tb_frame_transfer_receiver.sv
// ---------------------------------------------------------------------------
// tb_frame_transfer_receiver
//
// Self-checking bench for frame_transfer_receiver with MB_PIXELS=4 and
// FIFO_DEPTH=16. A frame-level reference model (queue of expected entries,
// beat position inside the macroblock, sticky flags) is stepped on every
// clock edge and compared with the DUT. A table of vectors covers a clean
// frame; hand-written sequences cover the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_frame_transfer_receiver;
    import frame_transfer_pkg::*;

    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            src_n;
    logic            active;
    teMacroBlockType mb_type;
    logic [23:0]     data;
    logic            mbend;
    logic            ready;
    logic            out_valid;
    logic [23:0]     out_data;
    teMacroBlockType out_type;
    logic            out_mbend;
    logic            out_fs;
    logic            out_ready;
    logic            frame_done;
    logic [15:0]     mbcount;
    logic            lerr;
    logic            terr;
    logic            trerr;
    logic            err_clr;

    always #5 clk = ~clk;

    frame_transfer_receiver #(.MB_PIXELS(MB), .FIFO_DEPTH(DEPTH)) dut (
        .ul1Clock(clk), .ul1Reset_n(rst_n), .ul1SrcReset_n(src_n),
        .ul1Active(active), .eMacroBlockType(mb_type), .ul24Rgb24Data(data),
        .ul1MacroBlockEnd(mbend), .ul1Ready(ready), .ul1OutValid(out_valid),
        .ul24OutData(out_data), .eOutType(out_type), .ul1OutMbEnd(out_mbend),
        .ul1OutFrameStart(out_fs), .ul1OutReady(out_ready), .ul1FrameDone(frame_done),
        .ul16MbCount(mbcount), .ul1LengthError(lerr), .ul1TypeError(terr),
        .ul1TruncError(trerr), .ul1ErrClear(err_clr)
    );

    int vectors     = 0;
    int miscompares = 0;
    int dut_pops    = 0;
    bit last_acc;

    // Reference model state
    logic [27:0]     q[$];
    bit              m_ready;
    bit              m_in_frame;
    bit              m_done;
    bit              m_lerr;
    bit              m_terr;
    bit              m_trerr;
    int              m_pc;
    int              m_cnt;
    teMacroBlockType m_type;

    typedef struct {
        logic        act;
        logic        end_b;
        logic [23:0] d;
        logic        e_valid;
        logic [23:0] e_data;
        logic        e_fs;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ready = 1'b0; m_in_frame = 1'b0; m_done = 1'b0;
        m_lerr = 1'b0; m_terr = 1'b0; m_trerr = 1'b0;
        m_pc = 0; m_cnt = 0; m_type = MB_TYPE_I;
    endtask

    task automatic model_step();
        bit acc, rd, sl, st, str;
        acc = active && m_ready;
        rd  = (q.size() != 0) && out_ready;
        sl = 1'b0; st = 1'b0; str = 1'b0;
        m_done = 1'b0;
        if (!src_n) begin
            q.delete();
            m_in_frame = 1'b0;
            m_pc       = 0;
            m_ready    = 1'b0;
        end else begin
            if (rd) void'(q.pop_front());
            if (acc) begin
                q.push_back({!m_in_frame, mb_type, mbend, data});
                if (!m_in_frame) begin
                    m_in_frame = 1'b1;
                    m_cnt      = 0;
                end
                if (m_pc == 0) m_type = mb_type;
                else if (mb_type != m_type) st = 1'b1;
                if (mbend || m_pc == MB - 1) begin
                    sl   = !(mbend && m_pc == MB - 1);
                    m_pc = 0;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_pc++;
                end
            end else if (m_in_frame && !active) begin
                if (m_pc == 0) m_done = 1'b1;
                else           str    = 1'b1;
                m_pc       = 0;
                m_in_frame = 1'b0;
            end
            m_ready = (q.size() < DEPTH);
        end
        if (err_clr) begin
            m_lerr = 1'b0; m_terr = 1'b0; m_trerr = 1'b0;
        end
        m_lerr  = m_lerr  | sl;
        m_terr  = m_terr  | st;
        m_trerr = m_trerr | str;
    endtask

    task automatic model_check();
        check("ready", ready, m_ready);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check("head", {out_fs, out_type, out_mbend, out_data}, q[0]);
        check("frame_done", frame_done, m_done);
        check("mb_count", mbcount, m_cnt);
        check("length_err", lerr, m_lerr);
        check("type_err", terr, m_terr);
        check("trunc_err", trerr, m_trerr);
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later
    task automatic cycle();
        @(posedge clk);
        last_acc = active & ready;
        if (out_valid & out_ready) dut_pops++;
        model_step();
        #1;
        model_check();
    endtask

    task automatic send(input logic a, input teMacroBlockType t, input logic [23:0] d, input logic e);
        active = a; mb_type = t; data = d; mbend = e;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; active = 1'b0; mbend = 1'b0; err_clr = 1'b0; src_n = 1'b1;
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_head", {out_fs, out_type, out_mbend, out_data}, 28'd0);
        check("rst_done", frame_done, 1'b0);
        check("rst_count", mbcount, 16'd0);
        check("rst_errs", {lerr, terr, trerr}, 3'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int p0;
        rst_n = 1'b1; src_n = 1'b1; active = 1'b0; mb_type = MB_TYPE_I;
        data = 24'd0; mbend = 1'b0; out_ready = 1'b0; err_clr = 1'b0;

        for (int k = 0; k < 8; k++) begin
            tbl[k] = '{1'b1, (k % 4 == 3), 24'h000100 + 24'(k), 1'b1, 24'h000100 + 24'(k),
                       (k == 0), 1'b0, (k >= 7) ? 16'd2 : ((k >= 3) ? 16'd1 : 16'd0)};
        end
        tbl[8] = '{1'b0, 1'b0, 24'd0, 1'b0, 24'd0, 1'b0, 1'b1, 16'd2};
        tbl[9] = '{1'b0, 1'b0, 24'd0, 1'b0, 24'd0, 1'b0, 1'b0, 16'd2};

        #2;
        do_reset();
        out_ready = 1'b1;
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);

        // Clean frame of two macroblocks
        for (int k = 0; k < 10; k++) begin
            send(tbl[k].act, MB_TYPE_P, tbl[k].d, tbl[k].end_b);
            check("tbl_valid", out_valid, tbl[k].e_valid);
            if (tbl[k].e_valid) begin
                check("tbl_data", out_data, tbl[k].e_data);
                check("tbl_fs", out_fs, tbl[k].e_fs);
            end
            check("tbl_done", frame_done, tbl[k].e_done);
            check("tbl_count", mbcount, tbl[k].e_cnt);
            check("tbl_errs", {lerr, terr, trerr}, 3'd0);
        end

        // Fill the FIFO with the sink stalled; source holds each beat until accepted
        out_ready = 1'b0;
        p0 = dut_pops;
        i  = 0;
        for (int cyc = 0; cyc < 100 && (dut_pops - p0) < 20; cyc++) begin
            out_ready = (cyc >= 25);
            active    = (i < 20);
            mb_type   = MB_TYPE_B;
            data      = 24'h00A000 + 24'(i);
            mbend     = (i % 4 == 3);
            cycle();
            if (last_acc) i++;
            if (cyc == 20) begin
                check("fill_ready", ready, 1'b0);
                check("fill_accepted", i, 16);
            end
        end
        check("fill_delivered", dut_pops - p0, 20);
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);

        // Short macroblock: MbEnd on the third beat
        out_ready = 1'b1;
        send(1'b1, MB_TYPE_I, 24'h000201, 1'b0);
        send(1'b1, MB_TYPE_I, 24'h000202, 1'b0);
        send(1'b1, MB_TYPE_I, 24'h000203, 1'b1);
        check("short_lerr", lerr, 1'b1);
        check("short_count", mbcount, 16'd1);
        for (int k = 0; k < 4; k++) send(1'b1, MB_TYPE_P, 24'h000210 + 24'(k), (k == 3));
        check("short_next_count", mbcount, 16'd2);
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        err_clr = 1'b1;
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        err_clr = 1'b0;
        check("short_clear", lerr, 1'b0);

        // Type change at pc=2
        p0 = dut_pops;
        send(1'b1, MB_TYPE_I, 24'h000301, 1'b0);
        send(1'b1, MB_TYPE_I, 24'h000302, 1'b0);
        send(1'b1, MB_TYPE_P, 24'h000303, 1'b0);
        send(1'b1, MB_TYPE_I, 24'h000304, 1'b1);
        check("type_err_set", terr, 1'b1);
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        check("type_all_out", dut_pops - p0, 4);
        err_clr = 1'b1;
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        err_clr = 1'b0;

        // Truncation at pc=2, then a new frame
        send(1'b1, MB_TYPE_B, 24'h000401, 1'b0);
        send(1'b1, MB_TYPE_B, 24'h000402, 1'b0);
        send(1'b0, MB_TYPE_B, 24'd0, 1'b0);
        check("trunc_set", trerr, 1'b1);
        check("trunc_no_done", frame_done, 1'b0);
        send(1'b0, MB_TYPE_B, 24'd0, 1'b0);
        send(1'b1, MB_TYPE_SKIP, 24'h000410, 1'b0);
        check("trunc_next_valid", out_valid, 1'b1);
        check("trunc_next_fs", out_fs, 1'b1);
        for (int k = 1; k < 4; k++) send(1'b1, MB_TYPE_SKIP, 24'h000410 + 24'(k), (k == 3));
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);

        // Source flush with 5 entries queued
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(1'b1, MB_TYPE_P, 24'h000500 + 24'(k), (k == 3));
        src_n = 1'b0;
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", ready, 1'b0);
        src_n = 1'b1;
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        check("flush_ready_back", ready, 1'b1);
        check("flush_count_kept", mbcount, 16'd1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            out_ready = (k < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            src_n     = ($urandom_range(0, 59) != 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) mb_type = teMacroBlockType'($urandom_range(0, 3));
            active = ($urandom_range(0, 9) != 0);
            data   = 24'($urandom);
            mbend  = ($urandom_range(0, 4) == 0);
            cycle();
        end
        src_n = 1'b1; err_clr = 1'b0;

        // Asynchronous reset in the middle of a frame
        out_ready = 1'b1;
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        send(1'b1, MB_TYPE_I, 24'h000601, 1'b0);
        send(1'b1, MB_TYPE_I, 24'h000602, 1'b0);
        do_reset();
        send(1'b0, MB_TYPE_I, 24'd0, 1'b0);
        check("post_rst_done", frame_done, 1'b0);
        send(1'b1, MB_TYPE_I, 24'h000701, 1'b0);
        check("post_rst_fs", out_fs, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
